// File: rtl/trin_bus_rx_if.sv
// Bus-side and stream-side signals of the tri-state bus reader.
// The reader takes the slave view; the bus driver/consumer side takes master.
interface trin_bus_rx_if #(
    parameter int N = 8
);
    logic [N-1:0] bus_d;
    logic         bus_oe;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport slave (
        input  bus_d,
        input  bus_oe,
        input  m_ready,
        output m_data,
        output m_valid
    );

    modport master (
        output bus_d,
        output bus_oe,
        output m_ready,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/trin_bus_rx.sv
// Tri-state bus reader: waits GUARD edges after bus_oe rises, captures
// one word per enable assertion into a show-ahead FIFO.
module trin_bus_rx #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int GUARD = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trin_bus_rx_if.slave           bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   glitch,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          push;
    logic          glitch_n;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          full, pop, wr_ok, drop;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        push     = 1'b0;
        glitch_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.bus_oe) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                if (!bus.bus_oe) begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    glitch_n = 1'b1;
                end else if (cnt == CW'(GUARD - 1)) begin
                    state_n = HOLD;
                    push    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!bus.bus_oe) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            glitch <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            glitch <= glitch_n;
        end
    end

    assign busy = (state != IDLE);

    assign full  = (level == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop   = bus.m_valid && bus.m_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign wr_ok = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= bus.bus_d;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            if (wr_ok && !pop)      level <= level + 1'b1;
            else if (!wr_ok && pop) level <= level - 1'b1;
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign bus.m_valid = (level != '0);
    assign bus.m_data  = bus.m_valid ? mem[rp] : '0;
endmodule
